// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and address mask for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] ADDR_LSB_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling: load extract+extend and store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;

  assign w_shifted = i_word >> {i_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_off[1] ? i_word[31:16] : i_word[15:0];
  assign w_bmask   = 32'h0000_00FF << {i_off, 3'b000};
  assign w_hmask   = i_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;

  always_comb begin
    o_load = 32'h0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0, w_half};
      F3_W:    o_load = i_word;
      default: o_load = 32'h0;
    endcase
  end

  // Replicate the store data across all lanes and let the mask pick the target lane.
  always_comb begin
    o_store = i_word;
    case (i_funct3)
      F3_B:    o_store = (i_word & ~w_bmask) | ({4{i_wdata[7:0]}} & w_bmask);
      F3_H:    o_store = (i_word & ~w_hmask) | ({2{i_wdata[15:0]}} & w_hmask);
      F3_W:    o_store = i_wdata;
      default: o_store = i_word;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: word-aligned RAM access, RMW for SB/SH, extended loads.
// LSU_MISALIGN_TRAP_EN: misaligned H/W requests error out; otherwise alignment is forced.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  lsu_state_t r_state, w_next;

  logic                  r_we;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic                  w_legal;
  logic                  w_is_h;
  logic                  w_is_w;
  logic                  w_mis;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_addr_forced;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_store;

  assign w_is_h = (req_funct3[1:0] == 2'b01);
  assign w_is_w = (req_funct3[1:0] == 2'b10);
  assign w_mis  = (w_is_h & req_addr[0]) | (w_is_w & (|req_addr[1:0]));

  always_comb begin
    w_legal = 1'b0;
    if (req_we)
      w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      w_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = !w_legal || w_mis;
`else
  assign w_err = !w_legal;
`endif

  // Drop the offset bits a halfword/word cannot use; only matters when trapping is off.
  always_comb begin
    w_addr_forced = req_addr;
    if (w_is_h) w_addr_forced[0]   = 1'b0;
    if (w_is_w) w_addr_forced[1:0] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= w_addr_forced;
        r_wdata <= req_wdata;
        r_err   <= w_err;
      end
      if (r_state == READ) r_data <= mem_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err)                              w_next = RESP;
          else if (req_we && req_funct3 == F3_W)  w_next = WRITE;
          else                                    w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .i_word   (r_data),
    .i_wdata  (r_wdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_comb begin
    req_ready  = (r_state == IDLE);
    mem_re     = (r_state == READ);
    mem_we     = (r_state == WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = (r_state == RESP);
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (r_state == READ || r_state == WRITE) mem_addr = r_addr & ADDR_LSB_MASK;
    if (r_state == WRITE) mem_wdata = w_store;
    if (r_state == RESP) begin
      resp_err = r_err;
      if (!r_we && !r_err) resp_rdata = w_load;
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-addressed data-memory port in the RISC-V pipeline. Accepts one load or store per transaction from the MEM stage and issues word-aligned reads/writes to the data RAM. The RAM reads asynchronously and writes on the clock edge. Sub-word stores are handled by read-modify-write; sub-word loads are lane-extracted and sign/zero-extended.

## Interface
- DATA_WIDTH, 32, width of data and address buses; must be 32
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle pulse, transaction complete
- resp_rdata  out  DATA_WIDTH  extended load data, valid with resp_valid; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_re  out  1  read enable to RAM
- mem_we  out  1  write enable to RAM, committed at next rising edge
- mem_addr  out  DATA_WIDTH  word-aligned address, bits [1:0] always 00
- mem_wdata  out  DATA_WIDTH  write word
- mem_rdata  in  DATA_WIDTH  combinational read word from RAM

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch req_we, req_funct3, req_addr and req_wdata, then classify the request:
  - Illegal funct3 goes to RESP with err. Illegal load funct3 is 011, 110, 111; illegal store funct3 is any value with funct3[2]=1 or 011.
  - Misaligned goes to RESP with err. Misaligned is H with addr[0]=1, or W with addr[1:0]≠00. No memory access occurs.
  - SW goes to WRITE.
  - All loads, SB and SH go to READ.
- READ: mem_re=1, mem_addr={addr[31:2],2'b00}. Capture mem_rdata into the data register.
  - Loads go to RESP.
  - SB and SH go to WRITE.
- WRITE: mem_we=1.
  - SW: mem_wdata=req_wdata.
  - SB: the captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: the captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Next state is RESP.
- Load extraction from the captured word:
  - LB: byte at lane addr[1:0], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: halfword at lane addr[1], sign-extended.
  - LHU: same halfword, zero-extended.
  - LW: whole word.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_err. Next state is IDLE. There is no response backpressure; the consumer must sample the pulse.
- Little-endian lane order: lane 0 = bits [7:0].

## Timing
- Reset (rst_n=0 at an edge):
  - state goes to IDLE.
  - resp_valid, resp_err, mem_re and mem_we go to 0.
  - resp_rdata, mem_addr and mem_wdata go to 0.
  - The latched request is discarded.
- Reset mid-transaction: no response is issued.
  - If reset is sampled in the same cycle as WRITE, mem_we is still high combinationally during that cycle, and the RAM write commits.
  - The spec treats this write as completed-but-unacknowledged.
- Latency, counted from the accept edge = cycle 0:
  - Loads: READ in cycle 1, resp_valid in cycle 2.
  - SW: WRITE in cycle 1, resp_valid in cycle 2.
  - SB/SH: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
  - Errors: resp_valid in cycle 1.
- Throughput: the next request is accepted in the cycle after RESP. Minimum spacing is 3 cycles for loads and SW, 4 for SB/SH.
- mem_re and mem_we are never high in the same cycle.
- mem_addr holds the aligned address in READ and WRITE, and 0 otherwise.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned requests complete with resp_err=1 and no memory access.
- LSU_MISALIGN_TRAP_EN undefined:
  - Alignment is forced: H ignores addr[0], W ignores addr[1:0].
  - The access proceeds as aligned with resp_err=0.
  - Illegal funct3 still errors.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, READ, WRITE, RESP).
  - ADDR_LSB_MASK.
- Sub-module lsu_lane_align (combinational):
  - Load extract/extend from (word, addr[1:0], funct3).
  - Store merge from (old word, wdata, addr[1:0], funct3).

## Test plan
- RAM[1]=0x8000_00F0; LB addr 0x4 -> resp_rdata=0xFFFF_FFF0, resp_valid in cycle 2, resp_err=0.
- Same word; LHU addr 0x6 -> 0x0000_8000; LH addr 0x6 -> 0xFFFF_8000.
- RAM[2]=0x1122_3344; SB addr 0x9 wdata 0xAB -> mem_we only in cycle 2, RAM[2]=0x1122_AB44, resp_valid in cycle 3.
- SW addr 0xC wdata 0xDEAD_BEEF, then LW addr 0xC -> 0xDEAD_BEEF; req_ready low between accept and RESP.
- With LSU_MISALIGN_TRAP_EN: SH addr 0x5 -> resp_err=1 in cycle 1, mem_re=mem_we=0 throughout. Without it: halfword written to lane 0 of word 1.
- rst_n=0 during READ of an SB -> no mem_we, no resp_valid; req_ready=1 after the reset edge.
